// File: rtl/gbt_rx_frameclk_phalgnr_dps_ctrl.sv
// Stratix V PLL dynamic phase shift sequencer for the GBT RX frame-clock phase aligner.
// Executes N-step up/down shift commands and tracks the frame-clock phase modulo one period.
module gbt_rx_frameclk_phalgnr_dps_ctrl #(
    parameter int         STEPS_PER_PERIOD = 144,
    parameter int         STEP_W           = 8,
    parameter logic [4:0] CNTSEL_VAL       = 5'd0,
    parameter int         PHASE_EN_CYCLES  = 2,
    parameter int         TIMEOUT          = 1023
) (
    input  logic              scanclk,
    input  logic              rst_n,
    input  logic              pll_locked,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic [STEP_W-1:0] cmd_steps,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [STEP_W-1:0] phase_pos,
    output logic              pll_phase_en,
    output logic              pll_updn,
    output logic [4:0]        pll_cntsel,
    input  logic              pll_phase_done
);
    localparam int PCNT_W = $clog2(PHASE_EN_CYCLES + 1);
    localparam int TCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [PCNT_W-1:0] PULSE_LAST = PCNT_W'(PHASE_EN_CYCLES - 1);
    localparam logic [TCNT_W-1:0] TMO_LAST   = TCNT_W'(TIMEOUT - 1);
    localparam logic [STEP_W-1:0] POS_MAX    = STEP_W'(STEPS_PER_PERIOD - 1);

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, WAIT_LO, WAIT_HI} state_t;

    state_t              state, state_next;
    logic                lock_meta, lock_s;
    logic                accept, step_ok, fail;
    logic                dir_q;
    logic [STEP_W-1:0]   remaining;
    logic [PCNT_W-1:0]   pulse_cnt;
    logic [TCNT_W-1:0]   tmo_cnt;

    function automatic logic [STEP_W-1:0] pos_step(input logic [STEP_W-1:0] pos, input logic up);
        if (up)
            return (pos == POS_MAX) ? '0 : pos + 1'b1;
        else
            return (pos == '0) ? POS_MAX : pos - 1'b1;
    endfunction

    assign cmd_ready = (state == IDLE) && lock_s;
    assign busy      = (state != IDLE);

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        step_ok    = 1'b0;
        fail       = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept = 1'b1;
                    if (cmd_steps != '0) state_next = SETUP;
                end
            end
            SETUP: state_next = PULSE;
            PULSE: if (pulse_cnt == PULSE_LAST) state_next = WAIT_LO;
            WAIT_LO: begin
                if (!pll_phase_done) begin
                    state_next = WAIT_HI;
                end else if (tmo_cnt == TMO_LAST) begin
                    fail       = 1'b1;
                    state_next = IDLE;
                end
            end
            WAIT_HI: begin
                if (pll_phase_done) begin
                    step_ok    = 1'b1;
                    state_next = (remaining == STEP_W'(1)) ? IDLE : SETUP;
                end else if (tmo_cnt == TMO_LAST) begin
                    fail       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Lock loss overrides everything: abandon the command without counting the step.
        if ((state != IDLE) && !lock_s) begin
            state_next = IDLE;
            fail       = 1'b1;
            step_ok    = 1'b0;
        end
    end

    always_ff @(posedge scanclk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta    <= 1'b0;
            lock_s       <= 1'b0;
            state        <= IDLE;
            done         <= 1'b0;
            err          <= 1'b0;
            phase_pos    <= '0;
            pll_phase_en <= 1'b0;
            pll_updn     <= 1'b0;
            pll_cntsel   <= CNTSEL_VAL;
            pulse_cnt    <= '0;
            tmo_cnt      <= '0;
        end else begin
            lock_meta    <= pll_locked;
            lock_s       <= lock_meta;
            state        <= state_next;
            done         <= (accept && (cmd_steps == '0)) || (step_ok && (state_next == IDLE));
            pll_phase_en <= (state_next == PULSE);
            if (accept)
                err <= 1'b0;
            else if (fail)
                err <= 1'b1;
            // updn/cntsel are loaded on entry to SETUP so they are stable before phase_en rises.
            if (state_next == SETUP) begin
                pll_updn   <= (state == IDLE) ? cmd_dir : dir_q;
                pll_cntsel <= CNTSEL_VAL;
            end
            pulse_cnt <= (state == PULSE) ? pulse_cnt + 1'b1 : '0;
            if ((state_next != state) || ((state != WAIT_LO) && (state != WAIT_HI)))
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + 1'b1;
            // The PLL relocks at its reset phase, so an unlocked PLL means position zero.
            if (!lock_s)
                phase_pos <= '0;
            else if (step_ok)
                phase_pos <= pos_step(phase_pos, dir_q);
        end
    end

    always_ff @(posedge scanclk) begin
        if (accept) begin
            dir_q     <= cmd_dir;
            remaining <= cmd_steps;
        end else if (step_ok) begin
            remaining <= remaining - 1'b1;
        end
    end

endmodule

// File: tb/tb_gbt_rx_frameclk_phalgnr_dps_ctrl.sv
// Bench for the DPS controller: PLL phase_done responder, scoreboard queue of expected
// command outcomes popped on done/err, plus direct timing and boundary checks.
module tb_gbt_rx_frameclk_phalgnr_dps_ctrl;

    logic       scanclk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_dir;
    logic [7:0] cmd_steps;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] phase_pos;
    logic       pll_phase_en;
    logic       pll_updn;
    logic [4:0] pll_cntsel;
    logic       pll_phase_done = 1'b1;

    gbt_rx_frameclk_phalgnr_dps_ctrl dut (
        .scanclk        (scanclk),
        .rst_n          (rst_n),
        .pll_locked     (pll_locked),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_dir        (cmd_dir),
        .cmd_steps      (cmd_steps),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .phase_pos      (phase_pos),
        .pll_phase_en   (pll_phase_en),
        .pll_updn       (pll_updn),
        .pll_cntsel     (pll_cntsel),
        .pll_phase_done (pll_phase_done)
    );

    always #5 scanclk = ~scanclk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // PLL responder: phase_done drops for 4 cycles after each phase_en pulse, unless stuck.
    logic model_stuck = 1'b0;
    logic en_d        = 1'b0;
    int   lo_cnt      = 0;
    always @(posedge scanclk) begin
        en_d <= pll_phase_en;
        if (model_stuck) begin
            pll_phase_done <= 1'b1;
        end else if (en_d && !pll_phase_en) begin
            pll_phase_done <= 1'b0;
            lo_cnt         <= 3;
        end else if (lo_cnt > 0) begin
            lo_cnt <= lo_cnt - 1;
        end else begin
            pll_phase_done <= 1'b1;
        end
    end

    typedef struct packed {
        logic [7:0] pos;
        logic [7:0] pulses;
        logic       is_err;
    } exp_t;

    exp_t exp_q[$];
    logic exp_updn  = 1'b0;
    int   pulses    = 0;
    int   en_w      = 0;
    int   updn_bad  = 0;
    logic en_prev   = 1'b0;
    logic err_prev  = 1'b0;

    task automatic pop_cmp(input string tag, input logic is_err);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_unexpected"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            check_eq({tag, "_kind"}, 32'(is_err), 32'(e.is_err));
            check_eq({tag, "_phase_pos"}, 32'(phase_pos), 32'(e.pos));
            check_eq({tag, "_pulses"}, pulses, 32'(e.pulses));
            check_eq({tag, "_updn_cntsel_bad"}, updn_bad, 0);
        end
        pulses   = 0;
        updn_bad = 0;
    endtask

    always @(negedge scanclk) begin
        if (!rst_n) begin
            pulses   = 0;
            en_w     = 0;
            updn_bad = 0;
            en_prev  = 1'b0;
            err_prev = 1'b0;
        end else begin
            if (pll_phase_en) begin
                if (!en_prev) pulses++;
                en_w++;
                if (pll_updn !== exp_updn || pll_cntsel !== 5'd0) updn_bad++;
            end else if (en_prev) begin
                check_eq("phase_en_width", en_w, 2);
                en_w = 0;
            end
            en_prev = pll_phase_en;
            if (done) pop_cmp("done", 1'b0);
            if (err && !err_prev) pop_cmp("err", 1'b1);
            err_prev = err;
        end
    end

    int exp_pos = 0;

    function automatic int pos_model(input int pos, input logic up);
        return up ? (pos + 1) % 144 : (pos + 143) % 144;
    endfunction

    // Returns at the first negedge after the accepting clock edge.
    task automatic send_cmd(input logic dir, input logic [7:0] steps);
        int n = 0;
        @(negedge scanclk);
        while (!cmd_ready && n < 100) begin
            @(negedge scanclk);
            n++;
        end
        check_eq("ready_before_cmd", 32'(cmd_ready), 1);
        exp_updn  = dir;
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_steps = steps;
        @(negedge scanclk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 500) begin
            @(negedge scanclk);
            n++;
        end
        check_eq("idle_in_time", 32'(busy), 0);
    endtask

    task automatic run_cmd(input logic dir, input logic [7:0] steps);
        exp_t e;
        for (int i = 0; i < int'(steps); i++) exp_pos = pos_model(exp_pos, dir);
        e.pos    = 8'(exp_pos);
        e.pulses = steps;
        e.is_err = 1'b0;
        exp_q.push_back(e);
        send_cmd(dir, steps);
        check_eq("err_cleared_on_accept", 32'(err), 0);
        if (steps == 8'd0) begin
            check_eq("zero_done_latency", 32'(done), 1);
            check_eq("zero_not_busy", 32'(busy), 0);
        end else begin
            check_eq("setup_busy", 32'(busy), 1);
            check_eq("setup_phase_en_low", 32'(pll_phase_en), 0);
            check_eq("setup_updn", 32'(pll_updn), 32'(dir));
            @(negedge scanclk);
            check_eq("pulse_phase_en_high", 32'(pll_phase_en), 1);
            wait_idle();
        end
        repeat (3) @(negedge scanclk);
        check_eq("final_phase_pos", 32'(phase_pos), 32'(exp_pos));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   cnt;
        int   rises;
        int   accepts;
        logic prev;

        rst_n      = 1'b0;
        pll_locked = 1'b0;
        cmd_valid  = 1'b0;
        cmd_dir    = 1'b0;
        cmd_steps  = 8'd0;
        #3;
        check_eq("rst_cmd_ready", 32'(cmd_ready), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_err", 32'(err), 0);
        check_eq("rst_phase_pos", 32'(phase_pos), 0);
        check_eq("rst_phase_en", 32'(pll_phase_en), 0);
        check_eq("rst_updn", 32'(pll_updn), 0);
        check_eq("rst_cntsel", 32'(pll_cntsel), 0);
        pll_locked = 1'b1;
        repeat (3) @(negedge scanclk);
        rst_n = 1'b1;

        // Three steps later, then wrap down through zero and back up.
        run_cmd(1'b1, 8'd3);
        run_cmd(1'b0, 8'd3);
        run_cmd(1'b0, 8'd1);
        run_cmd(1'b1, 8'd2);
        run_cmd(1'b1, 8'd0);

        // phase_done never drops: timeout in WAIT_LO.
        model_stuck = 1'b1;
        e.pos = 8'(exp_pos); e.pulses = 8'd1; e.is_err = 1'b1;
        exp_q.push_back(e);
        send_cmd(1'b1, 8'd1);
        cnt = 0;
        while (busy && cnt < 3000) begin
            cnt++;
            @(negedge scanclk);
        end
        check_eq("timeout_busy_cycles", cnt, 1026);
        check_eq("timeout_err", 32'(err), 1);
        check_eq("timeout_ready", 32'(cmd_ready), 1);
        model_stuck = 1'b0;
        repeat (2) @(negedge scanclk);
        run_cmd(1'b0, 8'd0);

        // Lock loss during the second of five steps.
        e.pos = 8'd0; e.pulses = 8'd2; e.is_err = 1'b1;
        exp_q.push_back(e);
        send_cmd(1'b1, 8'd5);
        rises = 0;
        prev  = 1'b0;
        for (int i = 0; i < 200 && rises < 2; i++) begin
            if (pll_phase_en && !prev) rises++;
            prev = pll_phase_en;
            if (rises < 2) @(negedge scanclk);
        end
        check_eq("lockloss_second_step_seen", rises, 2);
        pll_locked = 1'b0;
        repeat (3) @(posedge scanclk);
        #1;
        check_eq("lockloss_idle", 32'(busy), 0);
        check_eq("lockloss_err", 32'(err), 1);
        check_eq("lockloss_phase_en", 32'(pll_phase_en), 0);
        check_eq("lockloss_phase_pos", 32'(phase_pos), 0);
        check_eq("lockloss_ready", 32'(cmd_ready), 0);
        exp_pos = 0;
        repeat (10) @(negedge scanclk);
        check_eq("unlocked_ready", 32'(cmd_ready), 0);
        pll_locked = 1'b1;
        repeat (4) @(negedge scanclk);
        check_eq("relock_ready", 32'(cmd_ready), 1);

        // cmd_valid held high for the whole command: exactly one accept.
        exp_pos = pos_model(pos_model(exp_pos, 1'b0), 1'b0);
        e.pos = 8'(exp_pos); e.pulses = 8'd2; e.is_err = 1'b0;
        exp_q.push_back(e);
        exp_updn  = 1'b0;
        cmd_valid = 1'b1;
        cmd_dir   = 1'b0;
        cmd_steps = 8'd2;
        accepts   = 0;
        for (int i = 0; i < 300; i++) begin
            if (cmd_valid && cmd_ready) accepts++;
            @(negedge scanclk);
            if (done) begin
                cmd_valid = 1'b0;
                break;
            end
        end
        cmd_valid = 1'b0;
        check_eq("held_valid_accepts", accepts, 1);
        repeat (3) @(negedge scanclk);
        check_eq("held_valid_pos", 32'(phase_pos), 32'(exp_pos));

        // Asynchronous reset in the middle of a phase_en pulse.
        e.pos = 8'd0; e.pulses = 8'd0; e.is_err = 1'b0;
        exp_q.push_back(e);
        send_cmd(1'b1, 8'd3);
        @(negedge scanclk);
        check_eq("pre_reset_phase_en", 32'(pll_phase_en), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_phase_en", 32'(pll_phase_en), 0);
        check_eq("midrst_busy", 32'(busy), 0);
        check_eq("midrst_ready", 32'(cmd_ready), 0);
        check_eq("midrst_done", 32'(done), 0);
        check_eq("midrst_err", 32'(err), 0);
        check_eq("midrst_phase_pos", 32'(phase_pos), 0);
        check_eq("midrst_updn", 32'(pll_updn), 0);
        check_eq("midrst_cntsel", 32'(pll_cntsel), 0);
        @(negedge scanclk);
        #2;
        rst_n = 1'b1;
        exp_q.delete();
        exp_pos = 0;
        repeat (10) @(negedge scanclk);
        check_eq("after_reset_ready", 32'(cmd_ready), 1);
        check_eq("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
